rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rom_arbiter_if.sv | 33 +++
 rtl/rom_arb_starve_ctr.sv | 37 +++
 rtl/rom_arbiter.sv | 101 ++++++++++
 tb/tb_rom_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

    localparam int WORD_W           = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W            = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_A   = 2'd1,
        GNT_B   = 2'd2,
        FORCE_B = 2'd3
    } arb_state_e;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response bundle for both ROM ports plus the ROM address/data pair.
interface rom_arbiter_if #(parameter int ADDR_W = 12);

    logic                              a_req;
    logic [ADDR_W-1:0]                 a_addr;
    logic                              a_gnt;
    logic                              a_rvalid;
    logic [rom_arb_pkg::WORD_W-1:0]    a_rdata;
    logic                              a_err;

    logic                              b_req;
    logic [ADDR_W-1:0]                 b_addr;
    logic                              b_gnt;
    logic                              b_rvalid;
    logic [rom_arb_pkg::WORD_W-1:0]    b_rdata;
    logic                              b_err;

    logic [ADDR_W-1:0]                 rom_addr;
    logic [rom_arb_pkg::WORD_W-1:0]    rom_data;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, rom_data,
        output a_gnt, a_rvalid, a_rdata, a_err,
        output b_gnt, b_rvalid, b_rdata, b_err, rom_addr
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, rom_data,
        input  a_gnt, a_rvalid, a_rdata, a_err,
        input  b_gnt, b_rvalid, b_rdata, b_err, rom_addr
    );

endinterface

// File: rtl/rom_arb_starve_ctr.sv
// Saturating count of cycles port B has been waiting; flags when B must be forced.
module rom_arb_starve_ctr
    import rom_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (clr) begin
            starve_cnt_d = '0;
        end else if (inc && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign at_limit = (starve_cnt_q >= LIMIT_C);

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a combinational ROM: A has priority, B is
// forced through after STARVE_LIMIT lost cycles; read data returns one cycle later.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ADDR_W       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    rom_arbiter_if.slave  bus
);

    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0]   a_rdata_q, a_rdata_d;
    logic [WORD_W-1:0]   b_rdata_q, b_rdata_d;
    logic                a_err_q, a_err_d;
    logic                b_err_q, b_err_d;

    logic                a_gnt, b_gnt;
    logic                b_starving;
    logic                at_limit;
    logic                force_b;

    rom_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (b_starving),
        .clr      (!b_starving),
        .at_limit (at_limit)
    );

    assign force_b    = bus.b_req && at_limit;
    assign b_starving = bus.b_req && !b_gnt;

    // Grants are combinational, so they must be gated by reset explicitly.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (bus.b_req && (force_b || !bus.a_req)) begin
                b_gnt = 1'b1;
            end else if (bus.a_req) begin
                a_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = IDLE;
        rom_addr_d = rom_addr_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_err_d    = a_err_q;
        b_err_d    = b_err_q;
        if (b_gnt) begin
            state_d    = force_b ? FORCE_B : GNT_B;
            rom_addr_d = bus.b_addr;
            b_rdata_d  = bus.rom_data;
            b_err_d    = misaligned(bus.b_addr[1:0]);
        end else if (a_gnt) begin
            state_d    = GNT_A;
            rom_addr_d = bus.a_addr;
            a_rdata_d  = bus.rom_data;
            a_err_d    = misaligned(bus.a_addr[1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
        end
    end

    // ROM address follows the winner in the grant cycle and otherwise parks.
    assign bus.rom_addr = rom_addr_d;
    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = (state_q == GNT_A);
    assign bus.b_rvalid = (state_q == GNT_B) || (state_q == FORCE_B);
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.a_err    = a_err_q;
    assign bus.b_err    = b_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and randomized bench for rom_arbiter against a cycle-level reference model.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int ADDR_W = 12;
    localparam int LIMIT  = 4;
    localparam int DEPTH  = 1 << (ADDR_W - 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    rom_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem [DEPTH];
    assign bus.rom_data = mem[bus.rom_addr[ADDR_W-1:2]];

    int checks   = 0;
    int failures = 0;

    int                starve;
    bit                m_a_rv, m_b_rv;
    logic [31:0]       m_a_data, m_b_data;
    bit                m_a_err, m_b_err;
    logic [ADDR_W-1:0] m_addr;
    bit                last_ag, last_bg;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        starve   = 0;
        m_a_rv   = 1'b0;
        m_b_rv   = 1'b0;
        m_a_data = '0;
        m_b_data = '0;
        m_a_err  = 1'b0;
        m_b_err  = 1'b0;
        m_addr   = '0;
        last_ag  = 1'b0;
        last_bg  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_a_gnt",    32'(bus.a_gnt),    32'd0);
        chk("rst_b_gnt",    32'(bus.b_gnt),    32'd0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        chk("rst_a_err",    32'(bus.a_err),    32'd0);
        chk("rst_b_err",    32'(bus.b_err),    32'd0);
        chk("rst_a_rdata",  bus.a_rdata,       32'd0);
        chk("rst_b_rdata",  bus.b_rdata,       32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    endtask

    // Compare one cycle at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit                fb, eb, ea;
        logic [ADDR_W-1:0] e_addr;
        @(negedge clk);
        fb     = bus.b_req && (starve >= LIMIT);
        eb     = bus.b_req && (fb || !bus.a_req);
        ea     = bus.a_req && !eb;
        e_addr = ea ? bus.a_addr : (eb ? bus.b_addr : m_addr);

        chk("a_gnt",    32'(bus.a_gnt),               32'(ea));
        chk("b_gnt",    32'(bus.b_gnt),               32'(eb));
        chk("one_gnt",  32'(bus.a_gnt & bus.b_gnt),   32'd0);
        chk("rom_addr", 32'(bus.rom_addr),            32'(e_addr));
        chk("a_rvalid", 32'(bus.a_rvalid),            32'(m_a_rv));
        chk("b_rvalid", 32'(bus.b_rvalid),            32'(m_b_rv));
        chk("a_rdata",  bus.a_rdata,                  m_a_data);
        chk("b_rdata",  bus.b_rdata,                  m_b_data);
        chk("a_err",    32'(bus.a_err),               32'(m_a_err));
        chk("b_err",    32'(bus.b_err),               32'(m_b_err));

        m_a_rv = ea;
        m_b_rv = eb;
        if (ea) begin
            m_a_data = mem[int'(bus.a_addr) / 4];
            m_a_err  = (int'(bus.a_addr) % 4) != 0;
        end
        if (eb) begin
            m_b_data = mem[int'(bus.b_addr) / 4];
            m_b_err  = (int'(bus.b_addr) % 4) != 0;
        end
        if (bus.b_req && !eb) starve = (starve < 15) ? starve + 1 : 15;
        else                  starve = 0;
        m_addr  = e_addr;
        last_ag = ea;
        last_bg = eb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[1] = 32'h2402000A;
        bus.a_req  = 1'b0;
        bus.b_req  = 1'b0;
        bus.a_addr = '0;
        bus.b_addr = '0;
        model_reset();

        #2;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single A fetch of word 1
        bus.a_req  = 1'b1;
        bus.a_addr = 12'h004;
        step();
        bus.a_req = 1'b0;
        step();
        chk("fetch_a_rdata", bus.a_rdata, 32'h2402000A);
        chk("fetch_a_err",   32'(bus.a_err), 32'd0);

        // misaligned B load from word 2
        bus.b_req  = 1'b1;
        bus.b_addr = 12'h00A;
        step();
        bus.b_req = 1'b0;
        step();
        chk("load_b_rdata", bus.b_rdata, mem[2]);
        chk("load_b_err",   32'(bus.b_err), 32'd1);

        // back-to-back A fetches, then idle parking of rom_addr
        bus.a_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.a_addr = ADDR_W'(k * 4);
            step();
        end
        bus.a_req = 1'b0;
        step();
        step();
        step();
        chk("park_rom_addr", 32'(bus.rom_addr), 32'h008);

        // both ports saturated: A wins LIMIT cycles, then B once
        bus.a_req  = 1'b1;
        bus.b_req  = 1'b1;
        bus.a_addr = 12'h100;
        bus.b_addr = 12'h204;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("starve_pattern", 32'({last_ag, last_bg}), (i % 5 == 4) ? 32'd1 : 32'd2);
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        step();

        // reset asserted during a granted cycle
        bus.a_req  = 1'b1;
        bus.a_addr = 12'h010;
        #2;
        chk("pre_rst_a_gnt", 32'(bus.a_gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        bus.a_req = 1'b0;
        rst_n     = 1'b1;
        step();
        step();

        // randomized traffic with occasional B request drops and async resets
        for (int n = 0; n < 2000; n++) begin
            if (n % 500 == 250) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            if (last_ag || !bus.a_req) begin
                bus.a_req  = ($urandom % 3) != 0;
                bus.a_addr = ADDR_W'($urandom);
            end
            if (last_bg || !bus.b_req) begin
                bus.b_req  = ($urandom % 3) != 0;
                bus.b_addr = ADDR_W'($urandom);
            end else if ($urandom % 32 == 0) begin
                bus.b_req = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
